cpu_core_mc: RTL and testbench
==============================

// Module: cpu_core_mc
// PURPOSE
//   Parametrised multi-cycle successor to the 3-bit-PC single-cycle CPU. It holds an internal
//   program memory, a register file, an ALU, CF/SF/ZF flags and a FETCH/EXEC state machine.
//   It also adds a synchronous reset, a HALT state, wider data and more registers.
//   The program is loaded, and the memory read back, through a side port on the same clock.
// PARAMETERS
//   DATA_W  8  datapath, register and immediate width in bits
//   ADDR_W  4  program address width; program memory depth is 2**ADDR_W words
//   REG_AW  2  register-index width; the register file has 2**REG_AW registers
//   IW = 4+2*REG_AW+DATA_W (localparam) instruction width; default 16
// PORTS
//   clk         in   1       single clock; all state changes on the rising edge
//   rst         in   1       synchronous active-high reset
//   run         in   1       execute enable; 0 freezes the core in FETCH
//   prog_we     in   1       program memory write enable
//   prog_waddr  in   ADDR_W  program write address
//   prog_wdata  in   IW      program write data
//   dbg_raddr   in   ADDR_W  debug read address
//   dbg_rdata   out  IW      mem[dbg_raddr], combinational
//   out_data    out  DATA_W  last ALU result
//   out_valid   out  1       1-cycle pulse when out_data updates
//   pc          out  ADDR_W  current program counter
//   halted      out  1       high while in HALT
//   cf,sf,zf    out  1       registered flags
// BEHAVIOUR
//   Instruction fields: opc=[IW-1:IW-4], rd=next REG_AW bits, rs=next REG_AW bits, imm=[DATA_W-1:0].
//   Opcodes: 0 NOP, 1 ADD rd+=rs, 2 SUB rd-=rs, 3 ADDI rd+=imm, 4 SUBI rd-=imm, 5 MOVI rd=imm,
//     6 AND rd&=rs, 7 OR rd|=rs, 8 CMP rd-rs (flags only), 9 JMP, 10 JC, 11 JZ, 12 JS,
//     13-14 NOP, 15 HALT.
//   Reset (rst=1 at an edge): pc=0, all registers=0, flags=0, out_data=0, out_valid=0, halted=0,
//     state=FETCH. Reset has priority over everything and aborts any instruction in flight.
//     Program memory is NOT cleared by reset; prog_we is still honoured in a reset cycle.
//   FSM: FETCH -> EXEC -> FETCH. Each instruction takes 2 cycles.
//   FETCH, run=1: IR<=mem[pc], then go to EXEC.
//   FETCH, run=0: hold; no state changes except program writes.
//   EXEC: perform the ALU op, write rd back, update flags, update pc, return to FETCH.
//     run is ignored in EXEC, so an instruction already in flight completes.
//   HALT in EXEC: go to HALT, set halted=1, pc holds the HALT address. Only rst leaves HALT.
//   pc update: the next pc is the taken jump target if there is one, otherwise pc+1 mod 2**ADDR_W.
//     The target is imm[ADDR_W-1:0]; address 2**ADDR_W-1 wraps to 0.
//   Conditional jumps (JC/JZ/JS) test the flag values held before this EXEC. Jumps do not change flags.
//   Arithmetic works in DATA_W bits, modulo 2**DATA_W.
//   ADD/ADDI: cf = carry out of bit DATA_W-1.
//   SUB/SUBI/CMP: cf = borrow, i.e. cf=1 when A<B unsigned.
//   AND/OR/MOVI: cf=0.
//   For every ALU op (ADD..CMP): zf=(result==0), sf=result[DATA_W-1].
//   NOP, jumps and HALT leave the flags unchanged.
//   out_data/out_valid: on every ALU op (ADD..CMP), out_data<=result and out_valid=1 for one cycle.
//     out_valid is 0 in all other cycles.
//   Program port: mem[prog_waddr]<=prog_wdata at the edge.
//     A FETCH reading the same address in the same cycle gets the OLD word (read-before-write).
//   dbg_rdata is combinational and shows a write from the next cycle onward.
// TESTING
//   1. Reset, load MOVI r0,5; MOVI r1,3; ADD r0,r1; HALT, run=1
//      -> out_data=3 then 8, out_valid pulses, halted=1 after 8 cycles, pc=3.
//   2. MOVI r0,0xFF; ADDI r0,1 -> out_data=0x00, cf=1, zf=1, sf=0.
//      Then SUBI r0,1 -> out_data=0xFF, cf=1, sf=1, zf=0.
//   3. Loop: MOVI r0,3; SUBI r0,1; JZ 4; JMP 1; HALT -> exactly 3 SUBI results (2,1,0), then halted=1.
//   4. 16 NOPs with ADDR_W=4 -> pc wraps 15->0.
//      Drop run in FETCH for 5 cycles -> pc and registers frozen.
//   5. Assert rst during EXEC of an ADD -> no writeback; pc=0, flags=0, halted=0 next cycle.
//      Program memory is intact.
//   6. prog_we to the address being fetched, same cycle -> IR gets the old word.
//      dbg_rdata shows the new word one cycle later.

Source files
------------

// File: rtl/cpu_core_mc.sv
// Multi-cycle FETCH/EXEC CPU core with internal program memory, register file and ALU flags.
// Program memory is written and inspected through a side port sharing the core clock.
//
// state   | meaning
// S_FETCH | latch mem[pc] into ir when run=1, otherwise hold
// S_EXEC  | execute ir: ALU op / writeback / flags / pc update
// S_HALT  | stopped at the HALT address; only rst leaves
module cpu_core_mc #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 4,
    parameter  int REG_AW = 2,
    localparam int IW     = 4 + 2*REG_AW + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_waddr,
    input  logic [IW-1:0]     prog_wdata,
    input  logic [ADDR_W-1:0] dbg_raddr,
    output logic [IW-1:0]     dbg_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              cf,
    output logic              sf,
    output logic              zf
);
    localparam int NREG  = 2**REG_AW;
    localparam int DEPTH = 2**ADDR_W;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_SUBI = 4'd4;
    localparam logic [3:0] OP_MOVI = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_JC   = 4'd10;
    localparam logic [3:0] OP_JZ   = 4'd11;
    localparam logic [3:0] OP_JS   = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              cf_q, cf_d, sf_q, sf_d, zf_q, zf_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [IW-1:0]     mem_q [DEPTH];

    logic [3:0]        opc;
    logic [REG_AW-1:0] rd, rs;
    logic [DATA_W-1:0] imm, op_a, op_b;
    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cf, alu_en;

    // Memory is deliberately outside the reset domain; a fetch in the same cycle sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we) mem_q[prog_waddr] <= prog_wdata;
    end

    assign dbg_rdata = mem_q[dbg_raddr];

    assign opc  = ir_q[IW-1 -: 4];
    assign rd   = ir_q[IW-5 -: REG_AW];
    assign rs   = ir_q[IW-5-REG_AW -: REG_AW];
    assign imm  = ir_q[DATA_W-1:0];
    assign op_a = regs_q[rd];
    assign op_b = (opc == OP_ADDI || opc == OP_SUBI || opc == OP_MOVI) ? imm : regs_q[rs];
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        cf_d        = cf_q;
        sf_d        = sf_q;
        zf_d        = zf_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        alu_res     = '0;
        alu_cf      = 1'b0;
        alu_en      = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    ir_d    = mem_q[pc_q];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + ADDR_W'(1);
                case (opc)
                    OP_ADD, OP_ADDI: begin
                        alu_en = 1'b1; alu_res = sum[DATA_W-1:0]; alu_cf = sum[DATA_W];
                    end
                    OP_SUB, OP_SUBI, OP_CMP: begin
                        alu_en = 1'b1; alu_res = diff[DATA_W-1:0]; alu_cf = diff[DATA_W];
                    end
                    OP_MOVI: begin alu_en = 1'b1; alu_res = op_b; end
                    OP_AND:  begin alu_en = 1'b1; alu_res = op_a & op_b; end
                    OP_OR:   begin alu_en = 1'b1; alu_res = op_a | op_b; end
                    OP_JMP:  pc_d = imm[ADDR_W-1:0];
                    OP_JC:   if (cf_q) pc_d = imm[ADDR_W-1:0];
                    OP_JZ:   if (zf_q) pc_d = imm[ADDR_W-1:0];
                    OP_JS:   if (sf_q) pc_d = imm[ADDR_W-1:0];
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
                if (alu_en) begin
                    if (opc != OP_CMP) regs_d[rd] = alu_res;
                    cf_d        = alu_cf;
                    zf_d        = (alu_res == '0);
                    sf_d        = alu_res[DATA_W-1];
                    out_data_d  = alu_res;
                    out_valid_d = 1'b1;
                end
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            cf_q        <= 1'b0;
            sf_q        <= 1'b0;
            zf_q        <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            cf_q        <= cf_d;
            sf_q        <= sf_d;
            zf_q        <= zf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign cf        = cf_q;
    assign sf        = sf_q;
    assign zf        = zf_q;
endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: expected ALU results are queued as programs are set up
// and checked against each out_valid pulse; state, pc and flags are checked at chosen points.
module tb_cpu_core_mc;
    logic        clk = 1'b0;
    logic        rst, run, prog_we;
    logic [3:0]  prog_waddr, dbg_raddr;
    logic [15:0] prog_wdata, dbg_rdata;
    logic [7:0]  out_data;
    logic        out_valid, halted, cf, sf, zf;
    logic [3:0]  pc;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       cf;
        logic       sf;
        logic       zf;
    } exp_t;
    exp_t sb[$];

    cpu_core_mc dut (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we),
        .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .out_data(out_data), .out_valid(out_valid), .pc(pc), .halted(halted),
        .cf(cf), .sf(sf), .zf(zf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic expect_out(input logic [7:0] d, input logic c, input logic s, input logic z);
        exp_t e;
        e.d = d; e.cf = c; e.sf = s; e.zf = z;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] w);
        prog_we = 1'b1; prog_waddr = a; prog_wdata = w;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic wait_halt(input int bound);
        int n = 0;
        while (!halted && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    // Scoreboard side: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", {24'd0, out_data}, {24'd0, e.d});
                check("out_flags", {29'd0, cf, sf, zf}, {29'd0, e.cf, e.sf, e.zf});
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; prog_we = 1'b0;
        prog_waddr = '0; prog_wdata = '0; dbg_raddr = '0;

        // 1: basic program, reset state and HALT timing
        do_reset();
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_out", {23'd0, out_valid, out_data}, 32'd0);
        check("rst_flags", {29'd0, cf, sf, zf}, 32'd0);
        wr(0, enc(5, 0, 0, 8'd5));
        wr(1, enc(5, 1, 0, 8'd3));
        wr(2, enc(1, 0, 1, 8'd0));
        wr(3, enc(15, 0, 0, 8'd0));
        expect_out(8'd5, 0, 0, 0);
        expect_out(8'd3, 0, 0, 0);
        expect_out(8'd8, 0, 0, 0);
        run = 1'b1;
        cyc(7);
        check("t1_not_yet_halted", {31'd0, halted}, 32'd0);
        cyc(1);
        check("t1_halted", {31'd0, halted}, 32'd1);
        check("t1_pc", {28'd0, pc}, 32'd3);
        cyc(3);
        check("t1_pc_hold", {28'd0, pc}, 32'd3);
        check("t1_sb_empty", sb.size(), 32'd0);

        // 2: carry / zero / sign corners
        do_reset();
        wr(0, enc(5, 0, 0, 8'hFF));
        wr(1, enc(3, 0, 0, 8'h01));
        wr(2, enc(4, 0, 0, 8'h01));
        wr(3, enc(15, 0, 0, 8'h00));
        expect_out(8'hFF, 0, 1, 0);
        expect_out(8'h00, 1, 0, 1);
        expect_out(8'hFF, 1, 1, 0);
        run = 1'b1;
        wait_halt(40);
        check("t2_flags", {29'd0, cf, sf, zf}, {29'd0, 3'b110});
        check("t2_sb_empty", sb.size(), 32'd0);

        // 3: countdown loop with conditional and unconditional jumps
        do_reset();
        wr(0, enc(5, 0, 0, 8'd3));
        wr(1, enc(4, 0, 0, 8'd1));
        wr(2, enc(11, 0, 0, 8'd4));
        wr(3, enc(9, 0, 0, 8'd1));
        wr(4, enc(15, 0, 0, 8'd0));
        expect_out(8'd3, 0, 0, 0);
        expect_out(8'd2, 0, 0, 0);
        expect_out(8'd1, 0, 0, 0);
        expect_out(8'd0, 0, 0, 1);
        run = 1'b1;
        wait_halt(60);
        check("t3_pc", {28'd0, pc}, 32'd4);
        check("t3_sb_empty", sb.size(), 32'd0);

        // 4: pc wrap through 16 instructions, then freeze with run=0
        do_reset();
        wr(0, enc(5, 2, 0, 8'h5A));
        for (int a = 1; a < 16; a++) wr(4'(a), 16'h0000);
        expect_out(8'h5A, 0, 0, 0);
        run = 1'b1;
        cyc(30);
        check("t4_pc15", {28'd0, pc}, 32'd15);
        cyc(2);
        check("t4_pc_wrap", {28'd0, pc}, 32'd0);
        run = 1'b0;
        wr(1, enc(1, 2, 2, 8'd0));
        wr(2, enc(15, 0, 0, 8'd0));
        cyc(3);
        check("t4_pc_frozen", {28'd0, pc}, 32'd0);
        check("t4_no_valid_frozen", {31'd0, out_valid}, 32'd0);
        expect_out(8'h5A, 0, 0, 0);
        expect_out(8'hB4, 0, 1, 0);
        run = 1'b1;
        wait_halt(40);
        check("t4_pc_halt", {28'd0, pc}, 32'd2);
        check("t4_sb_empty", sb.size(), 32'd0);

        // 5: reset lands while ADD is in EXEC
        do_reset();
        wr(0, enc(5, 0, 0, 8'd7));
        wr(1, enc(1, 1, 0, 8'd0));
        wr(2, enc(15, 0, 0, 8'd0));
        expect_out(8'd7, 0, 0, 0);
        run = 1'b1;
        cyc(3);
        rst = 1'b1; run = 1'b0;
        cyc(1);
        rst = 1'b0;
        check("t5_pc", {28'd0, pc}, 32'd0);
        check("t5_halted", {31'd0, halted}, 32'd0);
        check("t5_flags", {29'd0, cf, sf, zf}, 32'd0);
        check("t5_out", {23'd0, out_valid, out_data}, 32'd0);
        dbg_raddr = 4'd1;
        #1;
        check("t5_mem_kept", {16'd0, dbg_rdata}, {16'd0, enc(1, 1, 0, 8'd0)});
        cyc(2);
        check("t5_sb_empty", sb.size(), 32'd0);

        // 6: program write to the address being fetched in the same cycle
        do_reset();
        wr(0, enc(5, 0, 0, 8'h11));
        dbg_raddr = 4'd0;
        run = 1'b1;
        prog_we = 1'b1; prog_waddr = 4'd0; prog_wdata = enc(5, 0, 0, 8'h22);
        expect_out(8'h11, 0, 0, 0);
        #1;
        check("t6_dbg_old", {16'd0, dbg_rdata}, {16'd0, enc(5, 0, 0, 8'h11)});
        @(negedge clk);
        prog_we = 1'b0; run = 1'b0;
        check("t6_dbg_new", {16'd0, dbg_rdata}, {16'd0, enc(5, 0, 0, 8'h22)});
        cyc(3);
        check("t6_pc", {28'd0, pc}, 32'd1);
        check("t6_sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
